// File: rtl/cordic_job_sequencer.sv
// Bus host for the CORDIC Controller: accepts one job, loads operands, pulses START,
// waits for completion or timeout, then holds the captured result until it is taken.
module cordic_job_sequencer #(
   parameter int unsigned p_WIDTH             = 32,
   parameter int unsigned p_TIMEOUT           = 63,
   parameter int unsigned p_CNTRL_START       = 0,
   parameter int unsigned p_CNTRL_RSLT_INT_EN = 1,
   parameter int unsigned p_FLAG_READY        = 31,
   parameter int unsigned p_FLAG_INP_ERROR    = 30,
   parameter int unsigned p_FLAG_OVF_ERROR    = 29,
   parameter int unsigned p_FLAG_X_OV         = 28,
   parameter int unsigned p_FLAG_Y_OV         = 27,
   parameter int unsigned p_FLAG_Z_OV         = 26
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               jobValid,
   output logic               jobReady,
   input  logic [p_WIDTH-1:0] jobX,
   input  logic [p_WIDTH-1:0] jobY,
   input  logic [p_WIDTH-1:0] jobZ,
   input  logic [p_WIDTH-1:0] jobCtrl,
   output logic [p_WIDTH-1:0] xInput,
   output logic [p_WIDTH-1:0] yInput,
   output logic [p_WIDTH-1:0] zInput,
   output logic [p_WIDTH-1:0] controlRegisterInput,
   input  logic [p_WIDTH-1:0] xOutput,
   input  logic [p_WIDTH-1:0] yOutput,
   input  logic [p_WIDTH-1:0] zOutput,
   input  logic [p_WIDTH-1:0] controlRegisterOutput,
   input  logic               interrupt,
   output logic               rsltValid,
   input  logic               rsltReady,
   output logic [p_WIDTH-1:0] rsltX,
   output logic [p_WIDTH-1:0] rsltY,
   output logic [p_WIDTH-1:0] rsltZ,
   output logic [5:0]         rsltFlags,
   output logic               rsltTimeout,
   output logic [15:0]        rsltCycles
);

   localparam logic [p_WIDTH-1:0] START_MASK  = {{(p_WIDTH-1){1'b0}}, 1'b1} << p_CNTRL_START;
   localparam logic [15:0]        TIMEOUT_CNT = 16'(p_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [p_WIDTH-1:0] x_in_q, x_in_d, y_in_q, y_in_d, z_in_q, z_in_d;
   logic [p_WIDTH-1:0] ctrl_q, ctrl_d;
   logic               start_q, start_d;
   logic               job_ready_q, job_ready_d;
   logic               rslt_valid_q, rslt_valid_d;
   logic [p_WIDTH-1:0] rslt_x_q, rslt_x_d, rslt_y_q, rslt_y_d, rslt_z_q, rslt_z_d;
   logic [5:0]         flags_q, flags_d;
   logic               timeout_q, timeout_d;
   logic [15:0]        cycles_q, cycles_d;
   logic [15:0]        wait_cnt_q, wait_cnt_d;

   logic               done_raw;
   logic               capture;
   logic [5:0]         flags_now;
   logic               unused_ctrl_out;

   // Completion uses the registered control word so the enable cannot change mid-job.
   assign done_raw  = interrupt |
                      (~ctrl_q[p_CNTRL_RSLT_INT_EN] & controlRegisterOutput[p_FLAG_READY]);
   assign flags_now = {controlRegisterOutput[p_FLAG_READY],
                       controlRegisterOutput[p_FLAG_INP_ERROR],
                       controlRegisterOutput[p_FLAG_OVF_ERROR],
                       controlRegisterOutput[p_FLAG_X_OV],
                       controlRegisterOutput[p_FLAG_Y_OV],
                       controlRegisterOutput[p_FLAG_Z_OV]};
   assign unused_ctrl_out = ^controlRegisterOutput;

   always_comb begin
      // NOTE: every next-state variable gets its hold value first; a branch that
      // forgets one then keeps the register instead of inferring a latch.
      state_d    = state_q;
      x_in_d     = x_in_q;
      y_in_d     = y_in_q;
      z_in_d     = z_in_q;
      ctrl_d     = ctrl_q;
      rslt_x_d   = rslt_x_q;
      rslt_y_d   = rslt_y_q;
      rslt_z_d   = rslt_z_q;
      flags_d    = flags_q;
      timeout_d  = timeout_q;
      cycles_d   = cycles_q;
      wait_cnt_d = wait_cnt_q;
      capture    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (jobValid && job_ready_q) begin
               x_in_d  = jobX;
               y_in_d  = jobY;
               z_in_d  = jobZ;
               ctrl_d  = jobCtrl & ~START_MASK;
               state_d = S_LOAD;
            end
         end
         S_LOAD:  state_d = S_START;
         S_START: begin
            wait_cnt_d = 16'd1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
            // The first WAIT cycle may still see interrupt/ready from the previous job.
            if (done_raw && (wait_cnt_q >= 16'd2)) begin
               capture   = 1'b1;
               timeout_d = 1'b0;
            end else if (wait_cnt_q == TIMEOUT_CNT) begin
               capture   = 1'b1;
               timeout_d = 1'b1;
            end
            if (capture) begin
               rslt_x_d = xOutput;
               rslt_y_d = yOutput;
               rslt_z_d = zOutput;
               flags_d  = flags_now;
               cycles_d = wait_cnt_q;
               state_d  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (rsltReady) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      start_d      = (state_d == S_START);
      job_ready_d  = (state_d == S_IDLE);
      rslt_valid_d = (state_d == S_HOLD);
   end

   // NOTE: state is updated with non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         x_in_q       <= '0;
         y_in_q       <= '0;
         z_in_q       <= '0;
         ctrl_q       <= '0;
         start_q      <= 1'b0;
         job_ready_q  <= 1'b0;
         rslt_valid_q <= 1'b0;
         rslt_x_q     <= '0;
         rslt_y_q     <= '0;
         rslt_z_q     <= '0;
         flags_q      <= '0;
         timeout_q    <= 1'b0;
         cycles_q     <= '0;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         x_in_q       <= x_in_d;
         y_in_q       <= y_in_d;
         z_in_q       <= z_in_d;
         ctrl_q       <= ctrl_d;
         start_q      <= start_d;
         job_ready_q  <= job_ready_d;
         rslt_valid_q <= rslt_valid_d;
         rslt_x_q     <= rslt_x_d;
         rslt_y_q     <= rslt_y_d;
         rslt_z_q     <= rslt_z_d;
         flags_q      <= flags_d;
         timeout_q    <= timeout_d;
         cycles_q     <= cycles_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   assign jobReady             = job_ready_q;
   assign rsltValid            = rslt_valid_q;
   assign xInput               = x_in_q;
   assign yInput               = y_in_q;
   assign zInput               = z_in_q;
   assign controlRegisterInput = ctrl_q | (start_q ? START_MASK : '0);
   assign rsltX                = rslt_x_q;
   assign rsltY                = rslt_y_q;
   assign rsltZ                = rslt_z_q;
   assign rsltFlags            = flags_q;
   assign rsltTimeout          = timeout_q;
   assign rsltCycles           = cycles_q;

endmodule

// File: doc/cordic_job_sequencer.md
# cordic_job_sequencer

Hardware bus host for the CORDIC `Controller`. It takes operand/control jobs from an upstream valid/ready stream and drives the controller's bus-side inputs: it loads operands, pulses START, then waits for the interrupt, the ready flag, or a timeout. It captures the results and flags and presents them on a downstream valid/ready stream. It sits between a job source (DMA or processor port) and `Controller`, and replaces the software/bench sequence that currently drives `BusInterface`.

## Interface
- p_WIDTH, 32, data width of x/y/z and the control register
- p_TIMEOUT, 63, maximum WAIT cycles before abort (2..65535)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- jobValid  in  1  upstream job valid
- jobReady  out  1  block can accept a job
- jobX, jobY, jobZ  in  p_WIDTH  operands, already in the controller's number/angle format
- jobCtrl  in  p_WIDTH  control word (mode, system, iterations, enables); its p_CNTRL_START bit is ignored
- xInput, yInput, zInput  out  p_WIDTH  to controller bus
- controlRegisterInput  out  p_WIDTH  to controller bus
- xOutput, yOutput, zOutput  in  p_WIDTH  from controller bus
- controlRegisterOutput  in  p_WIDTH  controller flags (p_FLAG_* positions)
- interrupt  in  1  controller interrupt
- rsltValid  out  1  result valid
- rsltReady  in  1  downstream accepts result
- rsltX, rsltY, rsltZ  out  p_WIDTH  captured outputs
- rsltFlags  out  6  {ready, inpError, overflowError, xOv, yOv, zOv}, taken from the controller's p_FLAG_* bits
- rsltTimeout  out  1  job aborted by timeout
- rsltCycles  out  16  WAIT cycles consumed

## Operation
- The FSM has five states: IDLE, LOAD, START, WAIT, HOLD.
- IDLE
  - jobReady = 1.
  - On jobValid&&jobReady, register jobX/Y/Z into x/y/zInput.
  - Register jobCtrl into controlRegisterInput with the START bit forced to 0.
  - Go to LOAD.
- LOAD
  - One cycle. Bus inputs are stable and START = 0.
  - Go to START.
- START
  - controlRegisterInput[p_CNTRL_START] = 1 for exactly this cycle.
  - Clear waitCnt. Go to WAIT.
- WAIT
  - START = 0. waitCnt increments every cycle and reads 1 in the first WAIT cycle.
  - The done condition is qualified only when waitCnt ≥ 2. This masks stale interrupt/ready left over from the previous job.
  - done = interrupt, OR (jobCtrl[p_CNTRL_RSLT_INT_EN] == 0 AND controlRegisterOutput[p_FLAG_READY]).
  - On done:
    - capture x/y/zOutput and the six flag bits;
    - set rsltCycles = waitCnt and rsltTimeout = 0;
    - go to HOLD.
  - Else, if waitCnt == p_TIMEOUT: capture the same way with rsltTimeout = 1, then go to HOLD.
  - If done and timeout occur in the same cycle, done wins (rsltTimeout = 0).
- HOLD
  - rsltValid = 1. All rslt* outputs are stable until the handshake.
  - On rsltReady, go to IDLE.
  - jobReady = 0.
- Only one job is in flight at a time. x/y/zInput and controlRegisterInput (except START) hold their values from acceptance until the next acceptance.
- rsltCycles saturates at 16'hFFFF.
- Reset:
  - state = IDLE; every output register is cleared to 0.
  - jobReady is 0 while rst = 1 and 1 from the first cycle after deassertion.
  - Reset during any state discards the job and the result, and drives START low immediately on the reset edge.

## Timing
- A job is accepted on edge N.
- LOAD is the cycle after N. START is high during the second cycle after N.
- The earliest qualified done is in the second WAIT cycle.
- The result is sampled on the edge where done is seen; rsltValid is high from the next cycle.
- After a rsltValid&&rsltReady handshake, jobReady = 1 the next cycle. Minimum job-to-job spacing is 6 cycles.
- No combinational path from any input to any output. jobReady and rsltValid are decoded from registered state.

## Test plan
- **Hyperbolic rotation** (q3.28): x=0, y=1.2051363584457304, z=0.5, 30 iter, RSLT_INT_EN=1.
  - Response: rsltX ≈ 0.5211 and rsltY ≈ 1.1276 within 1e-6; rsltFlags = 100000; rsltTimeout = 0.
  - START must be high for exactly one cycle.
- **Circular rotation, polling mode**: x=0.5, y=0, z=−45°, RSLT_INT_EN=0.
  - Completion is on the ready flag.
  - Response: rsltX ≈ 0.5823, rsltY ≈ −0.5823, rsltZ ≈ 0.
- **Backpressure**: hold rsltReady=0 for 10 cycles after rsltValid, with a second job presented (jobValid=1).
  - rslt* stay stable; jobReady stays 0; the second job is accepted 1 cycle after the handshake.
- **Timeout**: stub controller never asserts interrupt or ready, p_TIMEOUT=63.
  - rsltValid rises 1 cycle after WAIT cycle 63; rsltTimeout=1; rsltCycles=63.
- **Stale done**: hold interrupt=1 through START and the first WAIT cycle.
  - The result is not taken before waitCnt=2, so rsltCycles ≥ 2.
- **Reset mid-WAIT**: assert rst in WAIT cycle 5.
  - All outputs are 0 on the next cycle and START is never re-pulsed.
  - jobReady=1 on the first cycle after rst deasserts.
  - A new job then completes normally.
